// File: rtl/pixel_unstacker.sv
// pixel_unstacker: unpacks frame-buffer stream words (8 x RGB565) into one pixel per active cycle,
// resynchronising on underflow or frame misalignment. Define PIXEL_UNSTACKER_STATS_EN for err_count.
module pixel_unstacker #(
  parameter int                    PIXEL_WIDTH     = 16,
  parameter int                    PIXELS_PER_WORD = 8,
  parameter int                    H_ACTIVE        = 1280,
  parameter int                    V_ACTIVE        = 720,
  parameter logic [PIXEL_WIDTH-1:0] FILL_COLOR     = 16'h0000
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] s_axis_tdata,
  input  logic                                   s_axis_tvalid,
  output logic                                   s_axis_tready,
  input  logic                                   s_axis_tlast,
  input  logic                                   active_draw,
  input  logic [10:0]                            h_count,
  input  logic [9:0]                             v_count,
  output logic [PIXEL_WIDTH-1:0]                 pixel_out,
  output logic                                   pixel_out_valid,
  output logic                                   in_sync,
  output logic                                   resync_pulse,
  output logic [15:0]                            err_count
);

  localparam int DATA_WIDTH = PIXEL_WIDTH * PIXELS_PER_WORD;
  localparam int IDX_W      = $clog2(PIXELS_PER_WORD);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIXELS_PER_WORD - 1);

  typedef enum logic [1:0] {ST_SYNC, ST_WAIT_FRAME, ST_STREAM} state_t;

  state_t                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    word_q, word_d;
  logic                     full_q, full_d;
  logic                     last_q, last_d;
  logic [IDX_W-1:0]         index_q, index_d;
  logic [PIXEL_WIDTH-1:0]   pixel_q, pixel_d;
  logic                     valid_q, valid_d;
  logic                     resync_q, resync_d;
  logic                     ready_en_q;

  logic                     frame_start, frame_end, consume, slot, accept, abort;
  logic [PIXEL_WIDTH-1:0]   cur_pixel;

  assign frame_start = active_draw && (h_count == 11'd0) && (v_count == 10'd0);
  assign frame_end   = (h_count == 11'(H_ACTIVE - 1)) && (v_count == 10'(V_ACTIVE - 1));
  assign consume     = active_draw && (state_q == ST_STREAM);
  // A pixel slot is any consume, plus the frame-start cycle that promotes WAIT_FRAME to STREAM.
  assign slot        = consume || ((state_q == ST_WAIT_FRAME) && frame_start);
  assign cur_pixel   = word_q[index_q*PIXEL_WIDTH +: PIXEL_WIDTH];

  // ready_en_q keeps tready low while reset is held; tready never depends on tvalid.
  assign s_axis_tready = ready_en_q && (!full_q || (consume && (index_q == IDX_LAST)));
  assign accept        = s_axis_tvalid && s_axis_tready;

  always_comb begin
    // NOTE: every variable gets a default before the case, so no path leaves one unassigned (no latch).
    state_d  = state_q;
    word_d   = word_q;
    full_d   = full_q;
    last_d   = last_q;
    index_d  = index_q;
    pixel_d  = FILL_COLOR;
    valid_d  = 1'b0;
    resync_d = 1'b0;
    abort    = 1'b0;
    unique case (state_q)
      ST_SYNC: begin
        full_d  = 1'b0;
        last_d  = 1'b0;
        index_d = '0;
        if (accept && s_axis_tlast) state_d = ST_WAIT_FRAME;
      end
      ST_WAIT_FRAME, ST_STREAM: begin
        if (slot) begin
          valid_d = 1'b1;
          if (!full_q) begin
            abort = 1'b1;
          end else begin
            pixel_d = cur_pixel;
            state_d = ST_STREAM;
            if (index_q == IDX_LAST) begin
              index_d = '0;
              full_d  = 1'b0;
              // tlast must sit exactly on the word that ends the active frame.
              if (last_q != frame_end) abort = 1'b1;
            end else begin
              index_d = index_q + 1'b1;
            end
          end
        end
        if (accept) begin
          word_d = s_axis_tdata;
          last_d = s_axis_tlast;
          full_d = 1'b1;
        end
        if (abort) begin
          state_d  = ST_SYNC;
          full_d   = 1'b0;
          last_d   = 1'b0;
          index_d  = '0;
          resync_d = 1'b1;
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_SYNC;
      word_q     <= '0;
      full_q     <= 1'b0;
      last_q     <= 1'b0;
      index_q    <= '0;
      pixel_q    <= FILL_COLOR;
      valid_q    <= 1'b0;
      resync_q   <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of every other flop.
      state_q    <= state_d;
      word_q     <= word_d;
      full_q     <= full_d;
      last_q     <= last_d;
      index_q    <= index_d;
      pixel_q    <= pixel_d;
      valid_q    <= valid_d;
      resync_q   <= resync_d;
      ready_en_q <= 1'b1;
    end
  end

  assign pixel_out       = pixel_q;
  assign pixel_out_valid = valid_q;
  assign resync_pulse    = resync_q;
  assign in_sync         = (state_q == ST_STREAM);

`ifdef PIXEL_UNSTACKER_STATS_EN
  logic [15:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (resync_d && (err_count_q != 16'hFFFF)) err_count_d = err_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_count_q <= 16'h0000;
    else        err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`else
  assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pixel_unstacker.sv
// Scoreboard bench for pixel_unstacker on a reduced 16x4 raster (8 words per frame).
module tb_pixel_unstacker;

  localparam int H_ACT = 16;
  localparam int V_ACT = 4;
  localparam int H_TOT = 20;
  localparam int V_TOT = 6;
  localparam int WPF   = 8;
  localparam logic [15:0] FILL = 16'h0000;
`ifdef PIXEL_UNSTACKER_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  typedef struct {
    logic [127:0] data;
    logic         last;
    int           gap;
  } src_t;

  typedef struct {
    logic [15:0] pix;
    logic        resync;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] s_axis_tdata;
  logic         s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic         active_draw;
  logic [10:0]  h_count;
  logic [9:0]   v_count;
  logic [15:0]  pixel_out;
  logic         pixel_out_valid, in_sync, resync_pulse;
  logic [15:0]  err_count;

  src_t src_q[$];
  exp_t exp_q[$];
  bit   flush = 1'b0;
  int   errors = 0;
  int   checks = 0;

  pixel_unstacker #(
    .H_ACTIVE (H_ACT),
    .V_ACTIVE (V_ACT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tlast    (s_axis_tlast),
    .active_draw     (active_draw),
    .h_count         (h_count),
    .v_count         (v_count),
    .pixel_out       (pixel_out),
    .pixel_out_valid (pixel_out_valid),
    .in_sync         (in_sync),
    .resync_pulse    (resync_pulse),
    .err_count       (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] make_word(input int f, input int w);
    logic [127:0] d;
    for (int k = 0; k < 8; k++) d[16*k +: 16] = {4'(f), 4'(w), 4'(k), 4'h5};
    return d;
  endfunction

  task automatic push_filler(input logic last);
    src_t s;
    s.data = {8{16'hBEEF}};
    s.last = last;
    s.gap  = 0;
    src_q.push_back(s);
  endtask

  // gap_at: word withheld for 16 cycles; early_at: word carrying an early tlast (-1 = none).
  task automatic push_frame(input int f, input int gap_at, input int early_at, input bit spec_w0);
    src_t s;
    exp_t e;
    for (int w = 0; w < WPF; w++) begin
      s.data = make_word(f, w);
      if (spec_w0 && w == 0)
        s.data = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
      s.last = (w == WPF - 1) || (w == early_at);
      s.gap  = (w == gap_at) ? 16 : 0;
      src_q.push_back(s);
      if (gap_at >= 0 && w == gap_at) begin
        e.pix    = FILL;
        e.resync = 1'b1;
        exp_q.push_back(e);
      end
      if ((gap_at < 0 || w < gap_at) && (early_at < 0 || w <= early_at)) begin
        for (int k = 0; k < 8; k++) begin
          e.pix    = s.data[16*k +: 16];
          e.resync = (w == early_at) && (k == 7);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic wait_hv(input int h, input int v);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(h_count == 11'(h) && v_count == 10'(v)) && n < 400);
    check("wait_hv_timeout", {21'd0, h_count}, 32'(h));
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || src_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(exp_q.size() + src_q.size()), 32'd0);
  endtask

  // Video timing: h/v advance 1 time unit after each rising edge, starting in vertical blanking.
  initial begin
    h_count     = 11'd0;
    v_count     = 10'd4;
    active_draw = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (h_count == 11'(H_TOT - 1)) begin
        h_count = 11'd0;
        v_count = (v_count == 10'(V_TOT - 1)) ? 10'd0 : v_count + 10'd1;
      end else begin
        h_count = h_count + 11'd1;
      end
      active_draw = (h_count < 11'(H_ACT)) && (v_count < 10'(V_ACT));
    end
  end

  // Stream source: handshake observed on the falling edge, next word presented after the rising edge.
  initial begin
    bit fire;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    forever begin
      @(negedge clk);
      fire = s_axis_tvalid && s_axis_tready;
      @(posedge clk);
      #1;
      if (flush) begin
        src_q.delete();
        flush = 1'b0;
      end else if (fire) begin
        void'(src_q.pop_front());
      end
      if (src_q.size() != 0 && src_q[0].gap > 0) begin
        src_q[0].gap  = src_q[0].gap - 1;
        s_axis_tvalid = 1'b0;
      end else if (src_q.size() != 0) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = src_q[0].data;
        s_axis_tlast  = src_q[0].last;
      end else begin
        s_axis_tvalid = 1'b0;
      end
    end
  end

  // Monitor: every valid output pixel is popped from the scoreboard and compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (resync_pulse && !pixel_out_valid) check("resync_has_valid", {31'd0, pixel_out_valid}, 32'd1);
        if (pixel_out_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pixel: got %h expected none (t=%0t)", pixel_out, $time);
          end else begin
            e = exp_q.pop_front();
            check("pixel", {16'd0, pixel_out}, {16'd0, e.pix});
            check("resync_pulse", {31'd0, resync_pulse}, {31'd0, e.resync});
            check("in_sync", {31'd0, in_sync}, {31'd0, !e.resync});
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pixel", {16'd0, pixel_out}, {16'd0, FILL});
    check("rst_valid", {31'd0, pixel_out_valid}, 32'd0);
    check("rst_in_sync", {31'd0, in_sync}, 32'd0);
    check("rst_resync", {31'd0, resync_pulse}, 32'd0);
    check("rst_tready", {31'd0, s_axis_tready}, 32'd0);
    check("rst_err", {16'd0, err_count}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("tready_after_rst", {31'd0, s_axis_tready}, 32'd1);

    // Discard fillers until tlast, then two clean back-to-back frames.
    push_filler(1'b0);
    push_filler(1'b0);
    push_filler(1'b0);
    push_filler(1'b1);
    push_frame(1, -1, -1, 1'b1);
    push_frame(2, -1, -1, 1'b0);
    wait_hv(0, 0);
    check("pre_start_in_sync", {31'd0, in_sync}, 32'd0);
    check("pre_start_valid", {31'd0, pixel_out_valid}, 32'd0);
    wait_hv(1, 0);
    check("first_in_sync", {31'd0, in_sync}, 32'd1);
    check("first_pixel", {16'd0, pixel_out}, 32'h0000);
    wait_hv(6, 0);
    check("tready_pix6", {31'd0, s_axis_tready}, 32'd0);
    @(negedge clk);
    check("tready_pix7", {31'd0, s_axis_tready}, 32'd1);
    wait_drain(600);
    check("clean_in_sync", {31'd0, in_sync}, 32'd1);
    check("clean_err", {16'd0, err_count}, 32'd0);

    // Starve the word that starts line 2, then recover on the following frame.
    push_frame(3, 4, -1, 1'b0);
    push_frame(4, -1, -1, 1'b0);
    wait_drain(600);
    check("underflow_err", {16'd0, err_count}, 32'(STATS));

    // Early tlast on word 2, then recover.
    push_frame(5, -1, 2, 1'b0);
    push_frame(6, -1, -1, 1'b0);
    wait_drain(600);
    check("early_err", {16'd0, err_count}, 32'(2 * STATS));

    // Reset for one cycle mid-frame with a word held.
    push_frame(7, -1, -1, 1'b0);
    wait_hv(3, 1);
    #2;
    check("pre_reset_in_sync", {31'd0, in_sync}, 32'd1);
    rst_n = 1'b0;
    flush = 1'b1;
    exp_q.delete();
    #1;
    check("async_pixel", {16'd0, pixel_out}, {16'd0, FILL});
    check("async_valid", {31'd0, pixel_out_valid}, 32'd0);
    check("async_in_sync", {31'd0, in_sync}, 32'd0);
    check("async_tready", {31'd0, s_axis_tready}, 32'd0);
    check("async_err", {16'd0, err_count}, 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("tready_after_midrst", {31'd0, s_axis_tready}, 32'd1);

    // Without a tlast the block must stay out of sync across a frame start.
    push_filler(1'b0);
    push_filler(1'b0);
    wait_hv(0, 0);
    wait_hv(0, 1);
    check("no_tlast_in_sync", {31'd0, in_sync}, 32'd0);
    push_filler(1'b1);
    push_frame(8, -1, -1, 1'b0);
    wait_drain(600);
    check("reacquire_err", {16'd0, err_count}, 32'd0);
    check("exp_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
